// File: rtl/riscv_pkg.sv
// Shared constants for the register-file writeback path.
// Defines the port-id encoding used by the writeback arbiter.
package riscv_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_M = 1'b1
  } port_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a registered last-grant pointer.
// Reset leaves the pointer on M so that A wins the first contended cycle.
module rr_arb2
  import riscv_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  port_e last_q, last_d;

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_q == PORT_M) ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  // The pointer only moves when a granted request is actually taken.
  always_comb begin
    last_d = last_q;
    if (accept_i && grant_o[1]) begin
      last_d = PORT_M;
    end else if (accept_i && grant_o[0]) begin
      last_d = PORT_A;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      last_q <= PORT_M;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load writebacks and
// tracks pending destination registers for decode hazard checks.
module regfile_wb_arbiter
  import riscv_pkg::*;
#(
  parameter int DATA_W = riscv_pkg::DATA_W,
  parameter int ADDR_W = riscv_pkg::ADDR_W,
  parameter int NREGS  = riscv_pkg::NREGS
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              AValid,
  output logic              AReady,
  input  logic [ADDR_W-1:0] ARd,
  input  logic [DATA_W-1:0] AData,
  input  logic              MValid,
  output logic              MReady,
  input  logic [ADDR_W-1:0] MRd,
  input  logic [DATA_W-1:0] MData,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueRd,
  input  logic [ADDR_W-1:0] QueryRs1,
  input  logic [ADDR_W-1:0] QueryRs2,
  output logic              Rs1Busy,
  output logic              Rs2Busy,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData
);

  logic [1:0]        req;
  logic [1:0]        grant;
  logic              accept;
  logic [ADDR_W-1:0] selRd;
  logic [DATA_W-1:0] selData;

  logic              regWrite_q;
  logic [ADDR_W-1:0] writeReg_q;
  logic [DATA_W-1:0] writeData_q;
  logic [NREGS-1:0]  busy_q, busy_d;

  // Requests are masked during reset so neither Ready can rise.
  assign req    = {MValid & Reset, AValid & Reset};
  assign accept = |grant;

  rr_arb2 u_arb (
    .Clk      (Clk),
    .Reset    (Reset),
    .req_i    (req),
    .accept_i (accept),
    .grant_o  (grant)
  );

  assign AReady  = grant[0];
  assign MReady  = grant[1];
  assign selRd   = grant[1] ? MRd   : ARd;
  assign selData = grant[1] ? MData : AData;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      regWrite_q  <= 1'b0;
      writeReg_q  <= '0;
      writeData_q <= '0;
    end else begin
      regWrite_q <= accept && (selRd != REG_ZERO);
      if (accept) begin
        writeReg_q  <= selRd;
        writeData_q <= selData;
      end
    end
  end

  assign RegWrite  = regWrite_q;
  assign WriteReg  = writeReg_q;
  assign WriteData = writeData_q;

  // Set is applied after clear so a new producer issued in the commit cycle
  // keeps its register marked pending.
  always_comb begin
    busy_d = busy_q;
    if (regWrite_q) begin
      busy_d[writeReg_q] = 1'b0;
    end
    if (IssueValid) begin
      busy_d[IssueRd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign Rs1Busy = busy_q[QueryRs1];
  assign Rs2Busy = busy_q[QueryRs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
// Inputs change just after a rising edge; outputs are sampled 1ns later.
module tb_regfile_wb_arbiter;

  logic        Clk;
  logic        Reset;
  logic        AValid, MValid, IssueValid;
  logic        AReady, MReady;
  logic [4:0]  ARd, MRd, IssueRd, QueryRs1, QueryRs2;
  logic [31:0] AData, MData;
  logic        Rs1Busy, Rs2Busy;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;

  int compared   = 0;
  int mismatched = 0;

  regfile_wb_arbiter dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .AValid     (AValid),
    .AReady     (AReady),
    .ARd        (ARd),
    .AData      (AData),
    .MValid     (MValid),
    .MReady     (MReady),
    .MRd        (MRd),
    .MData      (MData),
    .IssueValid (IssueValid),
    .IssueRd    (IssueRd),
    .QueryRs1   (QueryRs1),
    .QueryRs2   (QueryRs2),
    .Rs1Busy    (Rs1Busy),
    .Rs2Busy    (Rs2Busy),
    .RegWrite   (RegWrite),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic applyStimulus();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b0;
    AValid = 1'b0; ARd = '0; AData = '0;
    MValid = 1'b0; MRd = '0; MData = '0;
    IssueValid = 1'b0; IssueRd = '0;
    QueryRs1 = 5'd5; QueryRs2 = 5'd0;

    applyStimulus();
    AValid = 1'b1; ARd = 5'd9; AData = 32'h1;
    #1;
    checkOutput("ready_in_reset", {31'd0, AReady}, 32'd0);
    applyStimulus();
    AValid = 1'b0;
    Reset = 1'b1;
    applyStimulus();
    checkOutput("idle_regwrite", {31'd0, RegWrite}, 32'd0);
    checkOutput("idle_aready", {31'd0, AReady}, 32'd0);
    checkOutput("idle_mready", {31'd0, MReady}, 32'd0);
    checkOutput("idle_rs1busy", {31'd0, Rs1Busy}, 32'd0);

    // Contention with A favoured out of reset
    AValid = 1'b1; ARd = 5'd5; AData = 32'd10;
    MValid = 1'b1; MRd = 5'd6; MData = 32'd7;
    #1;
    checkOutput("cont1_aready", {31'd0, AReady}, 32'd1);
    checkOutput("cont1_mready", {31'd0, MReady}, 32'd0);
    applyStimulus();
    checkOutput("cont2_aready", {31'd0, AReady}, 32'd0);
    checkOutput("cont2_mready", {31'd0, MReady}, 32'd1);
    checkOutput("cont2_regwrite", {31'd0, RegWrite}, 32'd1);
    checkOutput("cont2_writereg", {27'd0, WriteReg}, 32'd5);
    checkOutput("cont2_writedata", WriteData, 32'd10);
    applyStimulus();
    checkOutput("cont3_aready", {31'd0, AReady}, 32'd1);
    checkOutput("cont3_mready", {31'd0, MReady}, 32'd0);
    checkOutput("cont3_regwrite", {31'd0, RegWrite}, 32'd1);
    checkOutput("cont3_writereg", {27'd0, WriteReg}, 32'd6);
    checkOutput("cont3_writedata", WriteData, 32'd7);
    applyStimulus();
    AValid = 1'b0; MValid = 1'b0;
    checkOutput("cont4_writereg", {27'd0, WriteReg}, 32'd5);
    applyStimulus();
    checkOutput("cont5_regwrite", {31'd0, RegWrite}, 32'd0);

    // Single ALU write
    AValid = 1'b1; ARd = 5'd3; AData = 32'h0000_000D;
    #1;
    checkOutput("single_aready", {31'd0, AReady}, 32'd1);
    applyStimulus();
    AValid = 1'b0;
    checkOutput("single_regwrite", {31'd0, RegWrite}, 32'd1);
    checkOutput("single_writereg", {27'd0, WriteReg}, 32'd3);
    checkOutput("single_writedata", WriteData, 32'd13);
    applyStimulus();
    checkOutput("single_after_regwrite", {31'd0, RegWrite}, 32'd0);
    checkOutput("single_hold_writereg", {27'd0, WriteReg}, 32'd3);
    checkOutput("single_hold_writedata", WriteData, 32'd13);

    // Scoreboard set and commit-cycle clear
    IssueValid = 1'b1; IssueRd = 5'd6; QueryRs1 = 5'd6; QueryRs2 = 5'd6;
    #1;
    checkOutput("sb_before_issue", {31'd0, Rs1Busy}, 32'd0);
    applyStimulus();
    IssueValid = 1'b0;
    checkOutput("sb_rs1_set", {31'd0, Rs1Busy}, 32'd1);
    checkOutput("sb_rs2_set", {31'd0, Rs2Busy}, 32'd1);
    MValid = 1'b1; MRd = 5'd6; MData = 32'd99;
    #1;
    checkOutput("sb_mready", {31'd0, MReady}, 32'd1);
    applyStimulus();
    MValid = 1'b0;
    checkOutput("sb_commit_regwrite", {31'd0, RegWrite}, 32'd1);
    checkOutput("sb_commit_writedata", WriteData, 32'd99);
    checkOutput("sb_busy_in_commit", {31'd0, Rs1Busy}, 32'd1);
    applyStimulus();
    checkOutput("sb_cleared", {31'd0, Rs1Busy}, 32'd0);

    // Issue to the register that is committing this cycle
    IssueValid = 1'b1; IssueRd = 5'd6;
    applyStimulus();
    IssueValid = 1'b0;
    MValid = 1'b1; MRd = 5'd6; MData = 32'd42;
    applyStimulus();
    MValid = 1'b0;
    checkOutput("sb2_commit_regwrite", {31'd0, RegWrite}, 32'd1);
    IssueValid = 1'b1; IssueRd = 5'd6;
    applyStimulus();
    IssueValid = 1'b0;
    checkOutput("sb2_set_wins", {31'd0, Rs1Busy}, 32'd1);
    applyStimulus();
    checkOutput("sb2_still_busy", {31'd0, Rs1Busy}, 32'd1);

    // x0 writeback and issue
    AValid = 1'b1; ARd = 5'd0; AData = 32'hFFFF_FFFF;
    #1;
    checkOutput("x0_aready", {31'd0, AReady}, 32'd1);
    applyStimulus();
    AValid = 1'b0;
    checkOutput("x0_regwrite", {31'd0, RegWrite}, 32'd0);
    IssueValid = 1'b1; IssueRd = 5'd0; QueryRs2 = 5'd0;
    applyStimulus();
    IssueValid = 1'b0;
    checkOutput("x0_busy", {31'd0, Rs2Busy}, 32'd0);

    // Reset mid-transfer; last grant was A, so reset must restore A priority
    AValid = 1'b1; ARd = 5'd7; AData = 32'd55;
    #1;
    checkOutput("rst_aready", {31'd0, AReady}, 32'd1);
    Reset = 1'b0;
    applyStimulus();
    Reset = 1'b1;
    AValid = 1'b0;
    checkOutput("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    checkOutput("rst_busy_cleared", {31'd0, Rs1Busy}, 32'd0);
    checkOutput("rst_writereg", {27'd0, WriteReg}, 32'd0);
    AValid = 1'b1; ARd = 5'd1; AData = 32'd1;
    MValid = 1'b1; MRd = 5'd2; MData = 32'd2;
    #1;
    checkOutput("rst_ptr_aready", {31'd0, AReady}, 32'd1);
    checkOutput("rst_ptr_mready", {31'd0, MReady}, 32'd0);
    applyStimulus();
    AValid = 1'b0; MValid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
